booth_seq_multiplier: RTL and testbench

- Iterative, parametrised Booth multiplier.
- Successor to the fixed 32-bit Booth multiplier with enable-gated input and output registers.
- Adds WIDTH parametrisation, signed/unsigned mode per operation, a start/busy/done handshake and a multi-cycle datapath in place of the flat array.
- Sits between the operand registers and the product register in the multiplier test harness and datapath.

---
 rtl/booth_seq_multiplier.sv | 156 +++++++++++++++
 tb/tb_booth_seq_multiplier.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_multiplier.sv
// Iterative Booth multiplier with a start/busy/done handshake.
// Signed or unsigned operands are selected per operation. Both operands are extended by
// sign or zero before the Booth steps, so one signed datapath covers both modes.
// Build option BOOTH_RADIX4_EN: when defined, radix-4 (modified Booth) recoding is used and
// takes (WIDTH+2)/2 steps. When undefined, radix-2 recoding is used and takes WIDTH+1 steps.
module booth_seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_RADIX4_EN
  localparam int unsigned EW   = WIDTH + 2;
  localparam int unsigned ITER = EW / 2;
`else
  localparam int unsigned EW   = WIDTH + 1;
  localparam int unsigned ITER = EW;
`endif
  // hi is one bit wider than the extended operand, so hi and lo together form a
  // 2*EW+1 bit accumulator. The adder gets one more bit of headroom for +/-2M.
  localparam int unsigned HW = EW + 1;
  localparam int unsigned SW = EW + 2;
  localparam int unsigned CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t               state_q, state_d;
  logic [EW-1:0]        mcand_q, mcand_d;
  logic [HW-1:0]        hi_q, hi_d;
  logic [EW-1:0]        lo_q, lo_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [EW-1:0]        mcand_ext, mplier_ext;
  logic [SW-1:0]        hi_wide, m_wide, addend, sum;
  logic [HW-1:0]        step_hi;
  logic [EW-1:0]        step_lo;
  logic                 step_qm1;

  assign mcand_ext = {{(EW-WIDTH){signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
  assign mplier_ext = {{(EW-WIDTH){signed_mode & multiplier[WIDTH-1]}}, multiplier};
  assign hi_wide   = {hi_q[HW-1], hi_q};
  assign m_wide    = {{2{mcand_q[EW-1]}}, mcand_q};

  // One Booth step: recode multiplier bits, add the selected multiple, arithmetic shift.
  always_comb begin
    addend = '0;
`ifdef BOOTH_RADIX4_EN
    case ({lo_q[1:0], qm1_q})
      3'b001, 3'b010: addend = m_wide;
      3'b011:         addend = m_wide << 1;
      3'b100:         addend = -(m_wide << 1);
      3'b101, 3'b110: addend = -m_wide;
      default:        addend = '0;
    endcase
    sum      = hi_wide + addend;
    step_hi  = {sum[SW-1], sum[SW-1:2]};
    step_lo  = {sum[1:0], lo_q[EW-1:2]};
    step_qm1 = lo_q[1];
`else
    case ({lo_q[0], qm1_q})
      2'b01:   addend = m_wide;
      2'b10:   addend = -m_wide;
      default: addend = '0;
    endcase
    sum      = hi_wide + addend;
    step_hi  = sum[SW-1:1];
    step_lo  = {sum[0], lo_q[EW-1:1]};
    step_qm1 = lo_q[0];
`endif
  end

  // Next-state logic for the FSM and datapath registers, plus the handshake outputs.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    qm1_d     = qm1_q;
    count_d   = count_q;
    product_d = product_q;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = mcand_ext;
          hi_d    = '0;
          lo_d    = mplier_ext;
          qm1_d   = 1'b0;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        busy    = 1'b1;
        hi_d    = step_hi;
        lo_d    = step_lo;
        qm1_d   = step_qm1;
        count_d = count_q + 1'b1;
        if (count_q == CW'(ITER - 1)) begin
          // The product's low 2*WIDTH bits span all of lo plus the bottom of hi.
          product_d = {step_hi[2*WIDTH-EW-1:0], step_lo};
          state_d   = StDone;
        end
      end
      StDone: begin
        done = 1'b1;
        if (start) begin
          mcand_d = mcand_ext;
          hi_d    = '0;
          lo_d    = mplier_ext;
          qm1_d   = 1'b0;
          count_d = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset that also aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      qm1_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      qm1_q     <= qm1_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier at WIDTH=32: table vectors, random vectors
// against an arithmetic reference, and handshake/reset corner sequences.
module tb_booth_seq_multiplier;
  localparam int W = 32;
`ifdef BOOTH_RADIX4_EN
  localparam int ITER = (W + 2) / 2;
`else
  localparam int ITER = W + 1;
`endif
  localparam int BOUND = ITER + 20;

  logic          clk = 1'b0;
  logic          reset, start, signed_mode;
  logic [W-1:0]  multiplicand, multiplier;
  logic          busy, done;
  logic [2*W-1:0] product;

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           m;
    logic [2*W-1:0] exp;
  } tv_t;

  tv_t tv [9];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h, need 0x%016h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end
  endtask

  // Reference: extend by mode, multiply, keep the low 2*W bits.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic m);
    logic signed [63:0] pa, pb;
    pa = m ? {{32{a[31]}}, a} : {32'h0, a};
    pb = m ? {{32{b[31]}}, b} : {32'h0, b};
    return pa * pb;
  endfunction

  // Launch one operation and wait (bounded) for done; lat counts edges after the start edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                        output logic [63:0] p, output int lat);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    signed_mode  = m;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    p = product;
  endtask

  initial begin
    logic [63:0] p, exp1, exp2, prev;
    logic [31:0] ra, rb;
    logic        rm;
    int          lat;
    logic        saw_done;

    reset = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    multiplicand = '0;
    multiplier = '0;

    tv[0] = '{32'h00087234, 32'h00000348, 1'b1, 64'h000000001BB6BAA0};
    tv[1] = '{32'h00087234, 32'hFFFFFEFD, 1'b1, 64'hFFFFFFFFF7747564};
    tv[2] = '{32'hFFFFFEFD, 32'hFFFFFEFD, 1'b1, 64'h0000000000010609};
    tv[3] = '{32'hFFFFFEFD, 32'hFFFFFEFD, 1'b0, 64'hFFFFFDFA00010609};
    tv[4] = '{32'hB887CAAF, 32'h00000001, 1'b1, 64'hFFFFFFFFB887CAAF};
    tv[5] = '{32'hB887CAAF, 32'h00000001, 1'b0, 64'h00000000B887CAAF};
    tv[6] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    tv[7] = '{32'h00000000, 32'h50647236, 1'b1, 64'h0000000000000000};
    tv[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};

    // Reset, then idle for 10 cycles with nothing changing.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check64("reset_product", product, 64'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || done || product != 64'h0) saw_done = 1'b1;
    end
    check_int("idle_quiet", int'(saw_done), 0);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].m, p, lat);
      check64($sformatf("table%0d_product", i), p, tv[i].exp);
      check_int($sformatf("table%0d_latency", i), lat, ITER);
      @(negedge clk);
      check_int($sformatf("table%0d_done_pulse", i), int'(done), 0);
      check64($sformatf("table%0d_hold", i), product, tv[i].exp);
    end

    // Random operands and modes against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: ra = 32'h80000000;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h7FFFFFFF;
        default: ;
      endcase
      run_op(ra, rb, rm, p, lat);
      check64($sformatf("rand%0d_product a=%08h b=%08h m=%0d", i, ra, rb, rm), p,
              model(ra, rb, rm));
      check_int($sformatf("rand%0d_latency", i), lat, ITER);
    end

    // start pulsed mid-RUN with new operands must be ignored.
    prev = product;
    exp1 = model(32'h12345678, 32'hFEDCBA98, 1'b1);
    @(negedge clk);
    multiplicand = 32'h12345678;
    multiplier   = 32'hFEDCBA98;
    signed_mode  = 1'b1;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    repeat (5) begin
      @(negedge clk);
      lat++;
    end
    multiplicand = 32'hDEADBEEF;
    multiplier   = 32'h0BADF00D;
    signed_mode  = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    check_int("midrun_busy", int'(busy), 1);
    check64("midrun_product_stable", product, prev);
    while (!done && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    check64("midrun_product", product, exp1);
    check_int("midrun_latency", lat, ITER);
    @(negedge clk);
    check_int("midrun_not_queued", int'(busy), 0);

    // start held through DONE: back-to-back with no idle cycle.
    exp1 = model(32'hCAFEF00D, 32'h00C0FFEE, 1'b0);
    exp2 = model(32'h87654321, 32'h80000001, 1'b1);
    @(negedge clk);
    multiplicand = 32'hCAFEF00D;
    multiplier   = 32'h00C0FFEE;
    signed_mode  = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    check64("b2b_first_product", product, exp1);
    check_int("b2b_first_latency", lat, ITER);
    multiplicand = 32'h87654321;
    multiplier   = 32'h80000001;
    signed_mode  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_int("b2b_no_bubble", int'(busy), 1);
    lat = 0;
    while (!done && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    check64("b2b_second_product", product, exp2);
    check_int("b2b_second_latency", lat, ITER);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    multiplicand = 32'h0F0F0F0F;
    multiplier   = 32'hF0F0F0F0;
    signed_mode  = 1'b1;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (ITER / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_done", int'(done), 0);
    check64("abort_product", product, 64'h0);
    saw_done = 1'b0;
    repeat (ITER + 5) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check_int("abort_no_done", int'(saw_done), 0);
    run_op(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, p, lat);
    check64("after_abort_product", p, model(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1));
    check_int("after_abort_latency", lat, ITER);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
